// File: rtl/tx_ffe_eq.sv
// rtl/tx_ffe_eq.sv - N-tap transmit feed-forward equaliser with coefficient request handshake
// Produces a registered signed drive code per bit; new tap sets are rule-checked then swapped in atomically.
module tx_ffe_eq #(
    parameter int PRE_TAPS  = 1,
    parameter int POST_TAPS = 1,
    parameter int CW        = 6
) (
    input  logic                    bit_clk,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    elec_idle,
    input  logic                    select_reduced_swing,
    input  logic [CW-1:0]           FS,
    input  logic [CW-1:0]           LF,
    input  logic                    coef_req,
    input  logic [PRE_TAPS*CW-1:0]  coef_pre_in,
    input  logic [POST_TAPS*CW-1:0] coef_post_in,
    output logic                    coef_busy,
    output logic                    coef_ack,
    output logic                    coef_ok,
    output logic [CW-1:0]           c0_out,
    output logic [CW:0]             drive_code
);
    localparam int D  = PRE_TAPS + POST_TAPS + 1;
    localparam int SW = CW + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_APPLY,
        S_REJECT
    } state_t;

    state_t state_q, state_d;

    // Only the newest D-1 bits are stored; the oldest tap reads the register
    // output before it is shifted out, giving a full D-deep window in hist_d.
    logic [D-2:0]            hist_q;
    logic [D-1:0]            hist_d;

    logic [PRE_TAPS*CW-1:0]  pre_q, pre_sh_q;
    logic [POST_TAPS*CW-1:0] post_q, post_sh_q;
    logic [CW-1:0]           c0_q, fs_sh_q, lf_sh_q;
    logic [CW:0]             drive_q, drive_d;
    logic                    ack_q, ok_q;

    logic signed [SW-1:0]    sum_pre, sum_post, c0_calc, margin;
    logic                    pre_in_range, legal;
    logic signed [CW:0]      acc;

    assign hist_d = {hist_q, bit_in};

    always_comb begin
        sum_pre      = '0;
        sum_post     = '0;
        pre_in_range = 1'b1;
        for (int k = 0; k < PRE_TAPS; k++) begin
            sum_pre = sum_pre + $signed(SW'(pre_sh_q[k*CW +: CW]));
            if (pre_sh_q[k*CW +: CW] > (fs_sh_q >> 2)) begin
                pre_in_range = 1'b0;
            end
        end
        for (int k = 0; k < POST_TAPS; k++) begin
            sum_post = sum_post + $signed(SW'(post_sh_q[k*CW +: CW]));
        end
        c0_calc = $signed(SW'(fs_sh_q)) - sum_pre - sum_post;
        margin  = c0_calc - sum_pre - sum_post;
        legal   = pre_in_range && (c0_calc >= 0) && (margin >= $signed(SW'(lf_sh_q)));
    end

    always_comb begin
        state_d   = state_q;
        coef_busy = 1'b1;
        case (state_q)
            S_IDLE: begin
                coef_busy = 1'b0;
                if (coef_req) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK:  state_d = legal ? S_APPLY : S_REJECT;
            S_APPLY:  state_d = S_IDLE;
            S_REJECT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Wraparound in CW+1 bits is harmless: an applied set sums to at most FS,
    // so the final value always fits even if partial sums do not.
    always_comb begin
        acc = hist_d[PRE_TAPS] ? $signed({1'b0, c0_q}) : -$signed({1'b0, c0_q});
        for (int k = 0; k < PRE_TAPS; k++) begin
            if (hist_d[PRE_TAPS-1-k]) begin
                acc = acc - $signed({1'b0, pre_q[k*CW +: CW]});
            end else begin
                acc = acc + $signed({1'b0, pre_q[k*CW +: CW]});
            end
        end
        for (int k = 0; k < POST_TAPS; k++) begin
            if (hist_d[PRE_TAPS+1+k]) begin
                acc = acc - $signed({1'b0, post_q[k*CW +: CW]});
            end else begin
                acc = acc + $signed({1'b0, post_q[k*CW +: CW]});
            end
        end
        if (select_reduced_swing) begin
            acc = acc >>> 1;
        end
        drive_d = elec_idle ? '0 : acc;
    end

    always_ff @(posedge bit_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge bit_clk or posedge reset) begin
        if (reset) begin
            hist_q    <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            c0_q      <= '0;
            pre_sh_q  <= '0;
            post_sh_q <= '0;
            fs_sh_q   <= '0;
            lf_sh_q   <= '0;
            drive_q   <= '0;
            ack_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            hist_q  <= hist_d[D-2:0];
            drive_q <= drive_d;
            ack_q   <= (state_q == S_APPLY) || (state_q == S_REJECT);
            ok_q    <= (state_q == S_APPLY);
            if ((state_q == S_IDLE) && coef_req) begin
                pre_sh_q  <= coef_pre_in;
                post_sh_q <= coef_post_in;
                fs_sh_q   <= FS;
                lf_sh_q   <= LF;
            end
            // Swapping on this edge means drive_d for this edge still used the old set.
            if (state_q == S_APPLY) begin
                pre_q  <= pre_sh_q;
                post_q <= post_sh_q;
                c0_q   <= c0_calc[CW-1:0];
            end
        end
    end

    assign coef_ack   = ack_q;
    assign coef_ok    = ok_q;
    assign c0_out     = c0_q;
    assign drive_code = drive_q;

endmodule
